// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32 core types and sizes
package rv_pkg;

    localparam int XLEN       = 32;
    localparam int NB_OF_REGS = 32;
    localparam int REG_ADDR_W = $clog2(NB_OF_REGS);

    typedef logic [XLEN-1:0]       xlen_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one combinational read port with x0/en gating
// Optional write-through forwarding under REGFILE_BYPASS_EN.
module regfile_rd_port
    import rv_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int NB_REGS    = rv_pkg::NB_OF_REGS,
    parameter int ADDR_W     = $clog2(NB_REGS)
) (
    input  logic                                rstn,
    input  logic                                en,
    input  logic [ADDR_W-1:0]                   rd_addr,
    input  logic [NB_REGS-1:0][DATA_WIDTH-1:0]  mem,
    input  logic [NB_REGS-1:0]                  busy,
`ifdef REGFILE_BYPASS_EN
    input  logic                                we,
    input  logic [ADDR_W-1:0]                   wa,
    input  logic [DATA_WIDTH-1:0]               wd,
`endif
    output logic [DATA_WIDTH-1:0]               rd_data,
    output logic                                rd_busy
);

    always_comb begin
        rd_data = '0;
        rd_busy = 1'b0;
        if (rstn && en && (rd_addr != '0)) begin
            rd_data = mem[rd_addr];
            rd_busy = busy[rd_addr];
`ifdef REGFILE_BYPASS_EN
            // The value being written back supersedes both stored data and busy.
            if (we && (wa != '0) && (wa == rd_addr)) begin
                rd_data = wd;
                rd_busy = 1'b0;
            end
`endif
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - RV32 integer register file with pending-write scoreboard
// Optional write-through forwarding on reads under REGFILE_BYPASS_EN.
module regfile_sb
    import rv_pkg::*;
#(
    parameter int DATA_WIDTH  = XLEN,
    parameter int NB_OF_REGS  = rv_pkg::NB_OF_REGS,
    parameter int ADDR_W      = $clog2(NB_OF_REGS),
    parameter int NB_RD_PORTS = 2
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              en,
    input  logic [NB_RD_PORTS*ADDR_W-1:0]     rd_addr,
    output logic [NB_RD_PORTS*DATA_WIDTH-1:0] rd_data,
    output logic [NB_RD_PORTS-1:0]            rd_busy,
    input  logic                              we,
    input  logic [ADDR_W-1:0]                 wa,
    input  logic [DATA_WIDTH-1:0]             wd,
    input  logic                              claim,
    input  logic [ADDR_W-1:0]                 claim_addr,
    input  logic                              flush,
    output logic [NB_OF_REGS-1:0]             busy_vec
);

    logic [NB_OF_REGS-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
    logic [NB_OF_REGS-1:0]                 busy_q, busy_d;

    logic do_write, do_claim, do_flush;

    assign do_write = en && we && (wa != '0);
    assign do_claim = en && claim && (claim_addr != '0);
    assign do_flush = en && flush;

    // Ordering matters: a claim beats the release from a write, flush beats both.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (do_write) begin
            mem_d[wa]  = wd;
            busy_d[wa] = 1'b0;
        end
        if (do_claim) begin
            busy_d[claim_addr] = 1'b1;
        end
        if (do_flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q  <= '0;
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    for (genvar p = 0; p < NB_RD_PORTS; p++) begin : g_rd_port
        regfile_rd_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .NB_REGS    (NB_OF_REGS),
            .ADDR_W     (ADDR_W)
        ) u_rd_port (
            .rstn    (rstn),
            .en      (en),
            .rd_addr (rd_addr[p*ADDR_W +: ADDR_W]),
            .mem     (mem_q),
            .busy    (busy_q),
`ifdef REGFILE_BYPASS_EN
            .we      (we),
            .wa      (wa),
            .wd      (wd),
`endif
            .rd_data (rd_data[p*DATA_WIDTH +: DATA_WIDTH]),
            .rd_busy (rd_busy[p])
        );
    end

endmodule
